// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - op encodings, latency constant and tag-pipe entry for the multiply path
package mul_pkg;
   localparam int XLEN        = 32;
   localparam int MUL_LATENCY = 3;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_e;

   typedef struct packed {
      logic            valid;
      mul_op_e         op;
      logic [4:0]      rd;
      logic            corr;
      logic [XLEN-1:0] rs2;
   } mul_tag_t;
endpackage

// File: rtl/mul_issue_ctrl_if.sv
// rtl/mul_issue_ctrl_if.sv - decode request, multiplier, writeback and flush signals of the issue controller
interface mul_issue_ctrl_if #(
   parameter int XLEN = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic [1:0]        req_op_i;
   logic [4:0]        req_rd_i;
   logic [XLEN-1:0]   req_rs1_i;
   logic [XLEN-1:0]   req_rs2_i;
   logic              flush_i;
   logic              mul_start_o;
   logic              mul_signed_o;
   logic [XLEN-1:0]   mul_x_o;
   logic [XLEN-1:0]   mul_y_o;
   logic [2*XLEN-1:0] mul_result_i;
   logic              wb_valid_o;
   logic              wb_ready_i;
   logic [4:0]        wb_rd_o;
   logic [XLEN-1:0]   wb_data_o;
   logic              busy_o;

   modport slave (
      input  req_valid_i, req_op_i, req_rd_i, req_rs1_i, req_rs2_i, flush_i,
             mul_result_i, wb_ready_i,
      output req_ready_o, mul_start_o, mul_signed_o, mul_x_o, mul_y_o,
             wb_valid_o, wb_rd_o, wb_data_o, busy_o
   );

   modport master (
      output req_valid_i, req_op_i, req_rd_i, req_rs1_i, req_rs2_i, flush_i,
             mul_result_i, wb_ready_i,
      input  req_ready_o, mul_start_o, mul_signed_o, mul_x_o, mul_y_o,
             wb_valid_o, wb_rd_o, wb_data_o, busy_o
   );
endinterface

// File: rtl/mul_wb_fifo.sv
// rtl/mul_wb_fifo.sv - in-order writeback buffer with synchronous clear and occupancy count
module mul_wb_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 37,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_empty;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_do_pop  = pop_i & ~w_empty;
   // A full buffer still takes a push when the head leaves in the same cycle.
   assign w_do_push = push_i & (~w_full | w_do_pop);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (clear_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_do_push && !clear_i) r_mem[r_wr_ptr] <= din_i;
   end

   assign dout_o  = r_mem[r_rd_ptr];
   assign empty_o = w_empty;
   assign count_o = r_count;
endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue/writeback controller for the pipelined 32x32 multiplier
// Tags issued ops, corrects MULHSU, selects the result half and writes back in issue order.
module mul_issue_ctrl #(
   parameter int MUL_LATENCY = 3,
   parameter int FIFO_DEPTH  = 4,
   parameter int XLEN        = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   mul_issue_ctrl_if.slave bus
);
   import mul_pkg::*;

   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PIPE_D = MUL_LATENCY - 1;
   localparam int WB_W   = 5 + XLEN;

   mul_tag_t         r_pipe [PIPE_D];
   logic [CNT_W-1:0] r_inflight_cnt;
   logic [CNT_W-1:0] w_fifo_cnt;
   logic [CNT_W:0]   w_credit_used;
   logic             w_ready;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_fifo_empty;
   logic             w_wb_valid;
   mul_tag_t         w_new_tag;
   mul_tag_t         w_tail;
   logic [XLEN-1:0]  w_res_lo;
   logic [XLEN-1:0]  w_res_hi;
   logic [XLEN-1:0]  w_result;
   logic [WB_W-1:0]  w_fifo_din;
   logic [WB_W-1:0]  w_fifo_dout;

   // Registered counts only: a same-cycle pop frees its slot one cycle later.
   assign w_credit_used = {1'b0, r_inflight_cnt} + {1'b0, w_fifo_cnt};
   assign w_ready       = rst_n_i & ~bus.flush_i & (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));
   assign w_accept      = bus.req_valid_i & w_ready;

   assign bus.req_ready_o  = w_ready;
   assign bus.mul_start_o  = w_accept;
   assign bus.mul_signed_o = (bus.req_op_i == MUL_OP_MULH);
   assign bus.mul_x_o      = bus.req_rs1_i;
   assign bus.mul_y_o      = bus.req_rs2_i;

   always_comb begin
      w_new_tag       = '0;
      w_new_tag.valid = w_accept;
      w_new_tag.op    = mul_op_e'(bus.req_op_i);
      w_new_tag.rd    = bus.req_rd_i;
      w_new_tag.corr  = (bus.req_op_i == MUL_OP_MULHSU) & bus.req_rs1_i[XLEN-1];
      w_new_tag.rs2   = bus.req_rs2_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < PIPE_D; i++) r_pipe[i] <= '0;
      end else if (bus.flush_i) begin
         for (int i = 0; i < PIPE_D; i++) r_pipe[i].valid <= 1'b0;
      end else begin
         r_pipe[0] <= w_new_tag;
         for (int i = 1; i < PIPE_D; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign w_tail   = r_pipe[PIPE_D-1];
   assign w_push   = w_tail.valid;
   assign w_res_lo = bus.mul_result_i[XLEN-1:0];
   assign w_res_hi = bus.mul_result_i[2*XLEN-1:XLEN];

   always_comb begin
      w_result = w_res_hi;
      case (w_tail.op)
         MUL_OP_MUL:    w_result = w_res_lo;
         // The multiplier ran unsigned; a negative rs1 over-counts the high half by rs2.
         MUL_OP_MULHSU: w_result = w_res_hi - (w_tail.corr ? w_tail.rs2 : '0);
         default:       w_result = w_res_hi;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_inflight_cnt <= '0;
      end else if (bus.flush_i) begin
         r_inflight_cnt <= '0;
      end else if (w_accept && !w_push) begin
         r_inflight_cnt <= r_inflight_cnt + CNT_W'(1);
      end else if (!w_accept && w_push) begin
         r_inflight_cnt <= r_inflight_cnt - CNT_W'(1);
      end
   end

   assign w_fifo_din = {w_tail.rd, w_result};
   assign w_wb_valid = ~w_fifo_empty;
   assign w_pop      = w_wb_valid & bus.wb_ready_i & ~bus.flush_i;

   mul_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WB_W)
   ) u_wb_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clear_i (bus.flush_i),
      .push_i  (w_push),
      .din_i   (w_fifo_din),
      .pop_i   (w_pop),
      .dout_o  (w_fifo_dout),
      .empty_o (w_fifo_empty),
      .count_o (w_fifo_cnt)
   );

   assign bus.wb_valid_o = w_wb_valid;
   assign bus.wb_rd_o    = w_fifo_dout[WB_W-1:XLEN];
   assign bus.wb_data_o  = w_fifo_dout[XLEN-1:0];
   assign bus.busy_o     = (r_inflight_cnt != '0) | (w_fifo_cnt != '0);
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - self-checking bench for mul_issue_ctrl with a 3-stage multiplier model
module tb_mul_issue_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_issue_ctrl_if #(.XLEN(32)) bus();

   mul_issue_ctrl #(
      .MUL_LATENCY (3),
      .FIFO_DEPTH  (4),
      .XLEN        (32)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   // Falling-edge multiplier with three register stages; deliberately never reset.
   logic [63:0] m_s1 = '0;
   logic [63:0] m_s2 = '0;
   logic [63:0] m_s3 = '0;
   always @(negedge clk) begin
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      sx = {{32{bus.mul_x_o[31]}}, bus.mul_x_o};
      sy = {{32{bus.mul_y_o[31]}}, bus.mul_y_o};
      if (bus.mul_signed_o) m_s1 <= sx * sy;
      else                  m_s1 <= {32'b0, bus.mul_x_o} * {32'b0, bus.mul_y_o};
      m_s2 <= m_s1;
      m_s3 <= m_s2;
   end
   assign bus.mul_result_i = m_s3;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t exp_q[$];
   wb_t obs_q[$];
   int  obs_cyc[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s, prod_s;
      logic [63:0]        prod_u;
      sa     = {{32{a[31]}}, a};
      sb     = {{32{b[31]}}, b};
      ub_s   = {32'b0, b};
      prod_u = {32'b0, a} * {32'b0, b};
      case (op)
         2'd0:    return prod_u[31:0];
         2'd1:    begin prod_s = sa * sb;   return prod_s[63:32]; end
         2'd2:    begin prod_s = sa * ub_s; return prod_s[63:32]; end
         default: return prod_u[63:32];
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
      bus.req_valid_i = v;
      bus.req_op_i    = op;
      bus.req_rd_i    = rd;
      bus.req_rs1_i   = a;
      bus.req_rs2_i   = b;
   endtask

   // Scoreboard: at each falling edge, check any writeback against the model and log accepts.
   task automatic at_neg();
      wb_t o;
      wb_t e;
      @(negedge clk);
      cyc++;
      if (!rst_n || bus.flush_i) begin
         exp_q.delete();
         return;
      end
      if (bus.wb_valid_o && bus.wb_ready_i) begin
         o.rd   = bus.wb_rd_o;
         o.data = bus.wb_data_o;
         obs_q.push_back(o);
         obs_cyc.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", o.rd, o.data);
         end else begin
            e = exp_q.pop_front();
            if (o.rd !== e.rd || o.data !== e.data) begin
               n_fail++;
               $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                        o.rd, o.data, e.rd, e.data);
            end
         end
      end
      if (bus.req_valid_i && bus.req_ready_o) begin
         e.rd   = bus.req_rd_i;
         e.data = ref_result(bus.req_op_i, bus.req_rs1_i, bus.req_rs2_i);
         exp_q.push_back(e);
      end
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 2'd0, 5'd1, 32'd2, 32'd3);
      at_neg();
      n_checks += 3;
      if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b, required 0", bus.wb_valid_o); end
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy_o); end
      if (bus.mul_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, required 0", bus.mul_start_o); end
      to_pos();
      rst_n = 1'b1;
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      at_neg();
      n_checks += 2;
      if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.req_ready_o); end
      if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_wb_valid: got %b, required 0", bus.wb_valid_o); end
      to_pos();
   endtask

   task automatic test_mul_basic();
      int lat = -1;
      obs_q.delete();
      bus.wb_ready_i = 1'b1;
      drive(1'b1, 2'd0, 5'd3, 32'd7, 32'd6);
      at_neg();
      n_checks += 3;
      if (bus.mul_start_o !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b, required 1", bus.mul_start_o); end
      if (bus.mul_signed_o !== 1'b0) begin n_fail++; $display("FAIL basic_signed: got %b, required 0", bus.mul_signed_o); end
      if (bus.mul_x_o !== 32'd7 || bus.mul_y_o !== 32'd6) begin
         n_fail++; $display("FAIL basic_operands: got x=%h y=%h, required x=7 y=6", bus.mul_x_o, bus.mul_y_o);
      end
      to_pos();
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      for (int k = 1; k <= 6 && lat < 0; k++) begin
         at_neg();
         if (bus.wb_valid_o) begin
            lat = k;
            n_checks++;
            if (bus.wb_rd_o !== 5'd3 || bus.wb_data_o !== 32'd42) begin
               n_fail++; $display("FAIL basic_result: got rd=%0d data=%h, required rd=3 data=2a", bus.wb_rd_o, bus.wb_data_o);
            end
         end
         to_pos();
      end
      n_checks++;
      if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d, required 3", lat); end
   endtask

   task automatic test_op_variants();
      logic [1:0]  t_op  [4] = '{2'd1, 2'd3, 2'd2, 2'd2};
      logic [31:0] t_a   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] t_b   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
      logic [31:0] t_exp [4] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF};
      logic        t_sgn [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      obs_q.delete();
      bus.wb_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, t_op[i], 5'(20 + i), t_a[i], t_b[i]);
         at_neg();
         n_checks++;
         if (bus.mul_signed_o !== t_sgn[i]) begin
            n_fail++; $display("FAIL op_signed[%0d]: got %b, required %b", i, bus.mul_signed_o, t_sgn[i]);
         end
         to_pos();
      end
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      for (int k = 0; k < 10 && obs_q.size() < 4; k++) begin at_neg(); to_pos(); end
      n_checks++;
      if (obs_q.size() != 4) begin n_fail++; $display("FAIL op_count: got %0d, required 4", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         n_checks++;
         if (obs_q[i].rd !== 5'(20 + i) || obs_q[i].data !== t_exp[i]) begin
            n_fail++; $display("FAIL op_result[%0d]: got rd=%0d data=%h, required rd=%0d data=%h",
                               i, obs_q[i].rd, obs_q[i].data, 20 + i, t_exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int c0 = 0;
      obs_q.delete();
      obs_cyc.delete();
      bus.wb_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'd0, 5'(i), 32'(i), 32'(i + 1));
         at_neg();
         if (i == 0) c0 = cyc;
         n_checks++;
         if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, bus.req_ready_o); end
         to_pos();
      end
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      for (int k = 0; k < 12 && obs_q.size() < 8; k++) begin at_neg(); to_pos(); end
      n_checks++;
      if (obs_q.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d, required 8", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 8; i++) begin
         n_checks++;
         if (obs_q[i].rd !== 5'(i) || obs_q[i].data !== 32'(i * (i + 1)) || obs_cyc[i] != c0 + 3 + i) begin
            n_fail++; $display("FAIL b2b_wb[%0d]: got rd=%0d data=%h cyc=%0d, required rd=%0d data=%h cyc=%0d",
                               i, obs_q[i].rd, obs_q[i].data, obs_cyc[i], i, i * (i + 1), c0 + 3 + i);
         end
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      obs_q.delete();
      bus.wb_ready_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 2'd0, 5'(10 + acc), 32'(acc + 2), 32'd3);
         at_neg();
         if (bus.req_valid_i && bus.req_ready_o) acc++;
         to_pos();
      end
      n_checks++;
      if (acc != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d, required 4", acc); end
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      bus.wb_ready_i = 1'b1;
      at_neg();
      n_checks += 2;
      if (bus.wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_head_valid: got %b, required 1", bus.wb_valid_o); end
      if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_pop_cycle: got %b, required 0", bus.req_ready_o); end
      to_pos();
      at_neg();
      n_checks++;
      if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b, required 1", bus.req_ready_o); end
      to_pos();
      for (int k = 0; k < 8 && obs_q.size() < 4; k++) begin at_neg(); to_pos(); end
      n_checks++;
      if (obs_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d, required 4", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         n_checks++;
         if (obs_q[i].rd !== 5'(10 + i) || obs_q[i].data !== 32'((i + 2) * 3)) begin
            n_fail++; $display("FAIL bp_wb[%0d]: got rd=%0d data=%h, required rd=%0d data=%h",
                               i, obs_q[i].rd, obs_q[i].data, 10 + i, (i + 2) * 3);
         end
      end
   endtask

   task automatic test_flush(input bit use_reset);
      obs_q.delete();
      bus.wb_ready_i = 1'b0;
      drive(1'b1, 2'd0, 5'd1, 32'd11, 32'd13); at_neg(); to_pos();
      drive(1'b1, 2'd3, 5'd2, 32'hFFFF_0000, 32'd9); at_neg(); to_pos();
      drive(1'b1, 2'd2, 5'd4, 32'h8000_0001, 32'd5); at_neg(); to_pos();
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      if (use_reset) rst_n = 1'b0;
      else           bus.flush_i = 1'b1;
      at_neg();
      n_checks++;
      if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready_in_f: got %b, required 0", bus.req_ready_o); end
      if (!use_reset) begin
         n_checks++;
         if (bus.wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_buffered: got %b, required 1", bus.wb_valid_o); end
      end
      to_pos();
      bus.flush_i = 1'b0;
      rst_n = 1'b1;
      at_neg();
      n_checks += 3;
      if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_wb_valid: got %b, required 0", bus.wb_valid_o); end
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b, required 0", bus.busy_o); end
      if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b, required 1", bus.req_ready_o); end
      to_pos();
      bus.wb_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin at_neg(); to_pos(); end
      n_checks++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL flush_stale: got %0d writebacks, required 0", obs_q.size()); end
      drive(1'b1, 2'd0, 5'd7, 32'd3, 32'd5); at_neg(); to_pos();
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      for (int k = 0; k < 8 && obs_q.size() < 1; k++) begin at_neg(); to_pos(); end
      n_checks++;
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL flush_next_count: got %0d, required 1", obs_q.size());
      end else if (obs_q[0].rd !== 5'd7 || obs_q[0].data !== 32'd15) begin
         n_fail++; $display("FAIL flush_next_result: got rd=%0d data=%h, required rd=7 data=f", obs_q[0].rd, obs_q[0].data);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         bus.flush_i = ($urandom_range(0, 39) == 0);
         drive($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               pick_operand(), pick_operand());
         bus.wb_ready_i = ($urandom_range(0, 9) < 7);
         at_neg();
         to_pos();
      end
      bus.flush_i = 1'b0;
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      bus.wb_ready_i = 1'b1;
      for (int k = 0; k < 20 && bus.busy_o; k++) begin at_neg(); to_pos(); end
      n_checks += 2;
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rand_drain_busy: got %b, required 0", bus.busy_o); end
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain_pending: got %0d, required 0", exp_q.size()); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flush_i    = 1'b0;
      bus.wb_ready_i = 1'b1;
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_mul_basic();
      test_op_variants();
      test_back_to_back();
      test_backpressure();
      test_flush(1'b0);
      test_flush(1'b1);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
